// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with combinational strobes.
// Optional performance counters (cycle_cnt, instr_cnt) are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] ExtOp,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL
  } instr_t;

  state_t     state_reg;
  state_t     state_next;
  instr_t     instr;
  logic [1:0] ex_ext;
  logic       ex_srcb;
  logic [2:0] ex_aluop;

  always_comb begin
    instr = I_NOP;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_NOP;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b001111: instr = I_LUI;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_NOP;
    endcase
  end

  // Extender/ALU selects set up in EXEC and held through MEM and WB.
  always_comb begin
    ex_ext   = 2'b00;
    ex_srcb  = 1'b0;
    ex_aluop = 3'b000;
    case (instr)
      I_SUBU: ex_aluop = 3'b001;
      I_ORI: begin
        ex_ext   = 2'b01;
        ex_srcb  = 1'b1;
        ex_aluop = 3'b010;
      end
      I_LUI: begin
        ex_ext   = 2'b10;
        ex_srcb  = 1'b1;
        ex_aluop = 3'b011;
      end
      I_LW, I_SW: ex_srcb = 1'b1;
      I_BEQ: begin
        ex_ext   = 2'b11;
        ex_aluop = 3'b001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    ExtOp      = 2'b00;
    ALUSrcB    = 1'b0;
    ALUOp      = 3'b000;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'b00;
    MemToReg   = 2'b00;
    if (reset_n) begin
      case (state_reg)
        S_FETCH: begin
          MemRead    = 1'b1;
          state_next = S_FETCH;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          ExtOp      = 2'b11;
          state_next = S_EXEC;
          case (instr)
            I_J: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'b10;
              state_next = S_FETCH;
            end
            I_JAL: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'b10;
              RegWrite   = 1'b1;
              RegDst     = 2'b10;
              MemToReg   = 2'b10;
              state_next = S_FETCH;
            end
            I_JR: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'b11;
              state_next = S_FETCH;
            end
            I_NOP:   state_next = S_FETCH;
            default: state_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          ExtOp   = ex_ext;
          ALUSrcB = ex_srcb;
          ALUOp   = ex_aluop;
          case (instr)
            I_ADDU, I_SUBU, I_ORI, I_LUI: state_next = S_WB;
            I_LW, I_SW:                   state_next = S_MEM;
            I_BEQ: begin
              PCSrc      = 2'b01;
              PCWrite    = zero;
              state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          ExtOp   = ex_ext;
          ALUSrcB = ex_srcb;
          ALUOp   = ex_aluop;
          case (instr)
            I_LW: begin
              MemRead    = 1'b1;
              state_next = mem_ready ? S_WB : S_MEM;
            end
            I_SW: begin
              MemWrite   = 1'b1;
              state_next = mem_ready ? S_FETCH : S_MEM;
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_WB: begin
          ExtOp      = ex_ext;
          ALUSrcB    = ex_srcb;
          ALUOp      = ex_aluop;
          state_next = S_FETCH;
          case (instr)
            I_ADDU, I_SUBU: begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
            end
            I_ORI, I_LUI: RegWrite = 1'b1;
            I_LW: begin
              RegWrite = 1'b1;
              MemToReg = 2'b01;
            end
            default: ;
          endcase
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  assign state = state_reg;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instr_cnt_reg;
  logic        instr_done;

  // Only completions from a legal non-FETCH state count as retired instructions.
  assign instr_done = (state_reg inside {S_DECODE, S_EXEC, S_MEM, S_WB}) && (state_next == S_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_reg <= 32'd0;
      instr_cnt_reg <= 32'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (instr_done) instr_cnt_reg <= instr_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule
